pbs_battle_core: RTL and testbench

PBS_BATTLE_CORE -- requirements
Module: pbs_battle_core

---
 rtl/pbs_battle_core_if.sv | 33 +++
 rtl/pbs_battle_core.sv | 154 +++++++++++++++
 tb/tb_pbs_battle_core.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pbs_battle_core_if.sv
// Handshake, move-table config and status bundle for the battle core.
// master drives moves/config; slave is the core.
interface pbs_battle_core_if #(
    parameter int unsigned HP_W   = 4,
    parameter int unsigned MOVE_W = 2,
    parameter int unsigned ACC_W  = 4
) ();
    logic              new_game;
    logic              p_move_valid;
    logic [MOVE_W-1:0] p_move;
    logic              p_move_ready;
    logic              cfg_we;
    logic [MOVE_W-1:0] cfg_idx;
    logic [HP_W-1:0]   cfg_dmg;
    logic [ACC_W-1:0]  cfg_acc;
    logic [HP_W-1:0]   p_hp;
    logic [HP_W-1:0]   ai_hp;
    logic              turn;
    logic              last_hit;
    logic [MOVE_W-1:0] last_move;
    logic              game_over;
    logic              winner;

    modport master (
        output new_game, p_move_valid, p_move, cfg_we, cfg_idx, cfg_dmg, cfg_acc,
        input  p_move_ready, p_hp, ai_hp, turn, last_hit, last_move, game_over, winner
    );

    modport slave (
        input  new_game, p_move_valid, p_move, cfg_we, cfg_idx, cfg_dmg, cfg_acc,
        output p_move_ready, p_hp, ai_hp, turn, last_hit, last_move, game_over, winner
    );
endinterface

// File: rtl/pbs_battle_core.sv
// Turn-based battle engine: player move, LFSR-driven AI move, accuracy roll and
// saturating HP damage, with a small writable move table.
module pbs_battle_core #(
    parameter int unsigned HP_W      = 4,
    parameter int unsigned HP_INIT   = 9,
    parameter int unsigned MOVE_W    = 2,
    parameter int unsigned ACC_W     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic               clk,
    input logic               rst,
    pbs_battle_core_if.slave  bus
);
    localparam int unsigned      DEPTH   = 1 << MOVE_W;
    localparam logic [ACC_W-1:0] ACC_ALL = '1;
    localparam logic [HP_W-1:0]  HP_RST  = HP_W'(HP_INIT);

    typedef enum logic [2:0] {StPWait, StAiSel, StRoll, StApply, StDone} state_e;

    state_e            state_q, state_d;
    logic [15:0]       lfsr_q;
    logic              turn_q, turn_d;
    logic [MOVE_W-1:0] move_q, move_d;
    logic [ACC_W-1:0]  roll_q, roll_d;
    logic [HP_W-1:0]   p_hp_q, p_hp_d, ai_hp_q, ai_hp_d;
    logic              last_hit_q, last_hit_d;
    logic [MOVE_W-1:0] last_move_q, last_move_d;
    logic              winner_q, winner_d;

    logic [HP_W-1:0]   dmg_q [DEPTH];
    logic [ACC_W-1:0]  acc_q [DEPTH];

    logic [HP_W-1:0]   sel_dmg, tgt_hp, tgt_new;
    logic [ACC_W-1:0]  sel_acc;
    logic              hit, cfg_ok;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign cfg_ok = bus.cfg_we && !bus.new_game && (state_q == StPWait || state_q == StDone);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dmg_q[i] <= HP_W'(i + 1);
                acc_q[i] <= ACC_ALL >> i;
            end
        end else if (cfg_ok) begin
            dmg_q[bus.cfg_idx] <= bus.cfg_dmg;
            acc_q[bus.cfg_idx] <= bus.cfg_acc;
        end
    end

    assign sel_dmg = dmg_q[move_q];
    assign sel_acc = acc_q[move_q];
    assign tgt_hp  = turn_q ? p_hp_q : ai_hp_q;
    assign hit     = (sel_acc == ACC_ALL) || (roll_q < sel_acc);
    assign tgt_new = !hit ? tgt_hp : (tgt_hp > sel_dmg) ? tgt_hp - sel_dmg : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StPWait;
            turn_q      <= 1'b0;
            move_q      <= '0;
            roll_q      <= '0;
            p_hp_q      <= HP_RST;
            ai_hp_q     <= HP_RST;
            last_hit_q  <= 1'b0;
            last_move_q <= '0;
            winner_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            turn_q      <= turn_d;
            move_q      <= move_d;
            roll_q      <= roll_d;
            p_hp_q      <= p_hp_d;
            ai_hp_q     <= ai_hp_d;
            last_hit_q  <= last_hit_d;
            last_move_q <= last_move_d;
            winner_q    <= winner_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        turn_d      = turn_q;
        move_d      = move_q;
        roll_d      = roll_q;
        p_hp_d      = p_hp_q;
        ai_hp_d     = ai_hp_q;
        last_hit_d  = last_hit_q;
        last_move_d = last_move_q;
        winner_d    = winner_q;
        if (bus.new_game) begin
            state_d     = StPWait;
            turn_d      = 1'b0;
            p_hp_d      = HP_RST;
            ai_hp_d     = HP_RST;
            last_hit_d  = 1'b0;
            last_move_d = '0;
            winner_d    = 1'b0;
        end else begin
            unique case (state_q)
                StPWait: begin
                    if (bus.p_move_valid) begin
                        move_d  = bus.p_move;
                        turn_d  = 1'b0;
                        state_d = StRoll;
                    end
                end
                StAiSel: begin
                    move_d  = lfsr_q[MOVE_W-1:0];
                    turn_d  = 1'b1;
                    state_d = StRoll;
                end
                StRoll: begin
                    roll_d  = lfsr_q[ACC_W+7:8];
                    state_d = StApply;
                end
                StApply: begin
                    last_hit_d  = hit;
                    last_move_d = move_q;
                    if (turn_q) p_hp_d = tgt_new;
                    else        ai_hp_d = tgt_new;
                    if (tgt_new == '0) begin
                        state_d  = StDone;
                        winner_d = turn_q;
                    end else if (!turn_q) begin
                        state_d = StAiSel;
                    end else begin
                        state_d = StPWait;
                    end
                end
                StDone:  ;
                default: state_d = StPWait;
            endcase
        end
    end

    assign bus.p_move_ready = (state_q == StPWait);
    assign bus.p_hp         = p_hp_q;
    assign bus.ai_hp        = ai_hp_q;
    assign bus.turn         = turn_q;
    assign bus.last_hit     = last_hit_q;
    assign bus.last_move    = last_move_q;
    assign bus.game_over    = (state_q == StDone);
    assign bus.winner       = winner_q;
endmodule

// File: tb/tb_pbs_battle_core.sv
// Directed bench for pbs_battle_core: turn vectors with hand-computed HP plus
// hand sequences for reset, restart priority and config gating.
module tb_pbs_battle_core;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pbs_battle_core_if #(.HP_W(4), .MOVE_W(2), .ACC_W(4)) bus ();

    pbs_battle_core #(
        .HP_W(4), .HP_INIT(9), .MOVE_W(2), .ACC_W(4), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [15:0] nx(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [3:0] sat(input logic [3:0] h, input logic [3:0] d);
        return (h > d) ? h - d : 4'd0;
    endfunction

    // Reference LFSR, reset alongside the DUT
    logic [15:0] lfsr_m;
    always @(posedge clk or negedge rst) begin
        if (!rst) lfsr_m <= 16'hACE1;
        else      lfsr_m <= nx(lfsr_m);
    end

    logic [3:0] tbl_dmg [4];
    logic [3:0] tbl_acc [4];
    logic [3:0] mp, ma;
    bit         game_done;

    typedef struct {
        bit         setup;
        logic [3:0] dmg;
        logic [3:0] acc;
        logic [1:0] mv;
        logic [3:0] ai;
        logic [3:0] p;
        bit         hit_p;
        bit         hit_ai;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_all(input logic [3:0] dmg, input logic [3:0] acc);
        for (int i = 0; i < 4; i++) begin
            bus.cfg_we  = 1'b1;
            bus.cfg_idx = 2'(i);
            bus.cfg_dmg = dmg;
            bus.cfg_acc = acc;
            step();
            tbl_dmg[i] = dmg;
            tbl_acc[i] = acc;
        end
        bus.cfg_we = 1'b0;
    endtask

    task automatic restart();
        bus.new_game = 1'b1;
        step();
        bus.new_game = 1'b0;
        chk("ng_p_hp", bus.p_hp, 9);
        chk("ng_ai_hp", bus.ai_hp, 9);
        chk("ng_game_over", bus.game_over, 0);
        chk("ng_winner", bus.winner, 0);
        chk("ng_turn", bus.turn, 0);
        chk("ng_last_hit", bus.last_hit, 0);
        chk("ng_last_move", bus.last_move, 0);
        chk("ng_ready", bus.p_move_ready, 1);
        mp = 4'd9;
        ma = 4'd9;
        game_done = 1'b0;
    endtask

    // One player turn plus the AI reply; caller must be in the ready state
    task automatic do_turn(input logic [1:0] mv, input logic [3:0] e_ai, input logic [3:0] e_p,
                           input bit hit_p, input bit hit_ai, input bit cfg_roll);
        logic [15:0] l;
        logic [1:0]  ai_mv;
        int          lows;
        l = nx(nx(nx(lfsr_m)));
        ai_mv = l[1:0];
        lows = 0;
        chk("ready_idle", bus.p_move_ready, 1);
        bus.p_move_valid = 1'b1;
        bus.p_move = mv;
        step();
        bus.p_move_valid = 1'b0;
        if (cfg_roll) begin
            bus.cfg_we  = 1'b1;
            bus.cfg_idx = mv;
            bus.cfg_dmg = 4'd0;
            bus.cfg_acc = 4'd0;
        end
        if (!bus.p_move_ready) lows++;
        step();
        bus.cfg_we = 1'b0;
        if (!bus.p_move_ready) lows++;
        step();
        if (!bus.p_move_ready) lows++;
        chk("p_apply_ai_hp", bus.ai_hp, e_ai);
        chk("p_apply_last_hit", bus.last_hit, hit_p);
        chk("p_apply_last_move", bus.last_move, mv);
        chk("p_apply_turn", bus.turn, 0);
        if (e_ai == 4'd0) begin
            chk("p_win_game_over", bus.game_over, 1);
            chk("p_win_winner", bus.winner, 0);
            chk("p_win_ready", bus.p_move_ready, 0);
            game_done = 1'b1;
            return;
        end
        step();
        if (!bus.p_move_ready) lows++;
        chk("ai_sel_turn", bus.turn, 1);
        step();
        if (!bus.p_move_ready) lows++;
        step();
        chk("ai_apply_p_hp", bus.p_hp, e_p);
        chk("ai_apply_last_hit", bus.last_hit, hit_ai);
        chk("ai_apply_last_move", bus.last_move, ai_mv);
        if (e_p == 4'd0) begin
            chk("ai_win_game_over", bus.game_over, 1);
            chk("ai_win_winner", bus.winner, 1);
            game_done = 1'b1;
        end else begin
            chk("turn_end_ready", bus.p_move_ready, 1);
            chk("ready_low_cycles", 16'(lows), 5);
            chk("turn_end_game_over", bus.game_over, 0);
        end
    endtask

    // Expected outcome derived from the mirrored table and reference LFSR
    task automatic model_turn(input logic [1:0] mv);
        logic [15:0] l;
        logic [3:0]  rp, ra, ea, ep;
        logic [1:0]  am;
        bit          hp_, ha;
        l  = nx(lfsr_m);
        rp = l[11:8];
        l  = nx(nx(l));
        am = l[1:0];
        l  = nx(l);
        ra = l[11:8];
        hp_ = (tbl_acc[mv] == 4'hF) || (rp < tbl_acc[mv]);
        ea  = hp_ ? sat(ma, tbl_dmg[mv]) : ma;
        ha  = (tbl_acc[am] == 4'hF) || (ra < tbl_acc[am]);
        ep  = ha ? sat(mp, tbl_dmg[am]) : mp;
        if (ea == 4'd0) begin
            ha = 1'b0;
            ep = mp;
        end
        do_turn(mv, ea, ep, hp_, ha, 1'b0);
        ma = ea;
        mp = ep;
    endtask

    initial begin
        bus.new_game = 1'b0;
        bus.p_move_valid = 1'b0;
        bus.p_move = 2'd0;
        bus.cfg_we = 1'b0;
        bus.cfg_idx = 2'd0;
        bus.cfg_dmg = 4'd0;
        bus.cfg_acc = 4'd0;
        game_done = 1'b0;
        mp = 4'd9;
        ma = 4'd9;

        //            setup dmg    acc    mv    ai     p      hp    hai
        vecs[0] = '{1'b1, 4'd3,  4'd15, 2'd0, 4'd6,  4'd6,  1'b1, 1'b1};
        vecs[1] = '{1'b0, 4'd0,  4'd0,  2'd0, 4'd3,  4'd3,  1'b1, 1'b1};
        vecs[2] = '{1'b0, 4'd0,  4'd0,  2'd0, 4'd0,  4'd3,  1'b1, 1'b0};
        vecs[3] = '{1'b1, 4'd3,  4'd0,  2'd0, 4'd9,  4'd9,  1'b0, 1'b0};
        vecs[4] = '{1'b0, 4'd0,  4'd0,  2'd1, 4'd9,  4'd9,  1'b0, 1'b0};
        vecs[5] = '{1'b0, 4'd0,  4'd0,  2'd2, 4'd9,  4'd9,  1'b0, 1'b0};
        vecs[6] = '{1'b0, 4'd0,  4'd0,  2'd3, 4'd9,  4'd9,  1'b0, 1'b0};
        vecs[7] = '{1'b0, 4'd0,  4'd0,  2'd1, 4'd9,  4'd9,  1'b0, 1'b0};
        vecs[8] = '{1'b1, 4'd0,  4'd15, 2'd2, 4'd9,  4'd9,  1'b1, 1'b1};
        vecs[9] = '{1'b1, 4'd15, 4'd15, 2'd0, 4'd0,  4'd9,  1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_p_hp", bus.p_hp, 9);
        chk("rst_ai_hp", bus.ai_hp, 9);
        chk("rst_ready", bus.p_move_ready, 1);
        chk("rst_turn", bus.turn, 0);
        chk("rst_last_hit", bus.last_hit, 0);
        chk("rst_last_move", bus.last_move, 0);
        chk("rst_game_over", bus.game_over, 0);
        chk("rst_winner", bus.winner, 0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].setup) begin
                write_all(vecs[i].dmg, vecs[i].acc);
                restart();
            end
            do_turn(vecs[i].mv, vecs[i].ai, vecs[i].p, vecs[i].hit_p, vecs[i].hit_ai, 1'b0);
        end

        // DONE ignores moves and holds everything; AI never got a turn
        bus.p_move_valid = 1'b1;
        bus.p_move = 2'd0;
        repeat (3) step();
        bus.p_move_valid = 1'b0;
        chk("done_game_over", bus.game_over, 1);
        chk("done_ai_hp", bus.ai_hp, 0);
        chk("done_p_hp", bus.p_hp, 9);
        chk("done_turn", bus.turn, 0);
        chk("done_ready", bus.p_move_ready, 0);

        // new_game beats a simultaneous handshake and table write
        restart();
        bus.new_game = 1'b1;
        bus.p_move_valid = 1'b1;
        bus.p_move = 2'd0;
        bus.cfg_we = 1'b1;
        bus.cfg_idx = 2'd0;
        bus.cfg_dmg = 4'd1;
        bus.cfg_acc = 4'd15;
        step();
        bus.new_game = 1'b0;
        bus.p_move_valid = 1'b0;
        bus.cfg_we = 1'b0;
        chk("ng_drop_ready", bus.p_move_ready, 1);
        repeat (2) step();
        chk("ng_drop_ai_hp", bus.ai_hp, 9);
        chk("ng_drop_p_hp", bus.p_hp, 9);
        do_turn(2'd0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0);

        // Table write during ROLL must not land
        write_all(4'd3, 4'd15);
        restart();
        do_turn(2'd0, 4'd6, 4'd6, 1'b1, 1'b1, 1'b1);

        // Asynchronous reset in the APPLY cycle
        bus.p_move_valid = 1'b1;
        bus.p_move = 2'd0;
        step();
        bus.p_move_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("arst_p_hp", bus.p_hp, 9);
        chk("arst_ai_hp", bus.ai_hp, 9);
        chk("arst_ready", bus.p_move_ready, 1);
        chk("arst_turn", bus.turn, 0);
        chk("arst_last_hit", bus.last_hit, 0);
        chk("arst_game_over", bus.game_over, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tbl_dmg[i] = 4'(i + 1);
            tbl_acc[i] = 4'hF >> i;
        end
        mp = 4'd9;
        ma = 4'd9;
        game_done = 1'b0;
        step();
        chk("post_rst_ready", bus.p_move_ready, 1);

        // Full game on the default table
        for (int t = 0; t < 40 && !game_done; t++) model_turn(2'(t % 4));
        chk("model_game_over", bus.game_over, game_done);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
